game_controller: RTL and testbench



---
 rtl/game_controller_pkg.sv | 28 ++
 rtl/game_controller_key_press_detect.sv | 32 +++
 rtl/game_controller.sv | 172 +++++++++++++++++
 tb/tb_game_controller.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_controller_pkg.sv
// Shared constants for the Pong match controller: state codes, key codes,
// winner encodings and score width.
package game_controller_pkg;

    localparam int SCORE_W = 3;

    localparam logic [3:0] SERVE_KEY = 4'd1;
    localparam logic [3:0] PAUSE_KEY = 4'd4;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_PAUSE     = 3'd3,
        ST_POINT     = 3'd4,
        ST_GAME_OVER = 3'd5
    } state_e;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] score,
                                                   input logic [SCORE_W-1:0] limit);
        return (score >= limit) ? limit : score + 1'b1;
    endfunction

endpackage

// File: rtl/game_controller_key_press_detect.sv
// One keypad: 2-flop synchronizer, then a rising-match detector so a held
// code produces a single press event.
module key_press_detect
    import game_controller_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [3:0] keys_i,
    output logic       serve_press_o,
    output logic       pause_press_o
);

    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] prev_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= 4'd0;
            sync2_q <= 4'd0;
            prev_q  <= 4'd0;
        end else begin
            sync1_q <= keys_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign serve_press_o = (sync2_q == SERVE_KEY) && (prev_q != SERVE_KEY);
    assign pause_press_o = (sync2_q == PAUSE_KEY) && (prev_q != PAUSE_KEY);

endmodule

// File: rtl/game_controller.sv
// Pong match sequencer: serve/play/pause/point/game-over FSM and both scores.
// Optional GAME_CONTROLLER_AUTO_SERVE_EN: auto-serve after SERVE_TIMEOUT ticks.
module game_controller
    import game_controller_pkg::*;
#(
    parameter int WIN_SCORE     = 7,
    parameter int POINT_HOLD    = 60,
    parameter int SERVE_TIMEOUT = 180
) (
    input  logic               CLOCK_25,
    input  logic               reset,
    input  logic               frame_tick_i,
    input  logic [3:0]         keys_1_i,
    input  logic [3:0]         keys_2_i,
    input  logic               miss_1_i,
    input  logic               miss_2_i,
    output logic               run_o,
    output logic               ball_reset_o,
    output logic               serve_side_o,
    output logic [SCORE_W-1:0] score_1_o,
    output logic [SCORE_W-1:0] score_2_o,
    output logic [1:0]         winner_o,
    output logic [2:0]         state_o
);

    localparam logic [SCORE_W-1:0] WIN_LIM  = SCORE_W'(WIN_SCORE);
    localparam logic [8:0]         HOLD_LIM = 9'(POINT_HOLD);

    logic serve_1, pause_1, serve_2, pause_2;

    key_press_detect u_keys_1 (
        .clk_i         (CLOCK_25),
        .reset_i       (reset),
        .keys_i        (keys_1_i),
        .serve_press_o (serve_1),
        .pause_press_o (pause_1)
    );

    key_press_detect u_keys_2 (
        .clk_i         (CLOCK_25),
        .reset_i       (reset),
        .keys_i        (keys_2_i),
        .serve_press_o (serve_2),
        .pause_press_o (pause_2)
    );

    state_e             state_q;
    logic [7:0]         tick_q;
    logic [SCORE_W-1:0] score_1_q, score_2_q;
    logic [SCORE_W-1:0] score_1_d, score_2_d;
    logic [1:0]         winner_q;
    logic               serve_side_q, run_q, ball_reset_q;
    logic [8:0]         tick_inc_d;
    logic               serve_own, point_done, serve_timeout;

    assign tick_inc_d = {1'b0, tick_q} + 9'd1;
    assign score_1_d  = sat_inc(score_1_q, WIN_LIM);
    assign score_2_d  = sat_inc(score_2_q, WIN_LIM);
    assign serve_own  = serve_side_q ? serve_2 : serve_1;
    // Compare the post-increment count so POINT_HOLD=0 still waits for one tick.
    assign point_done = frame_tick_i && (tick_inc_d >= HOLD_LIM);

`ifdef GAME_CONTROLLER_AUTO_SERVE_EN
    localparam logic [8:0] TIMEOUT_LIM = 9'(SERVE_TIMEOUT);
    assign serve_timeout = frame_tick_i && (tick_inc_d >= TIMEOUT_LIM);
`else
    logic unused_serve_timeout;
    assign unused_serve_timeout = (SERVE_TIMEOUT != 0);
    assign serve_timeout        = 1'b0;
`endif

    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            tick_q       <= 8'd0;
            score_1_q    <= '0;
            score_2_q    <= '0;
            winner_q     <= WIN_NONE;
            serve_side_q <= 1'b0;
            run_q        <= 1'b0;
            ball_reset_q <= 1'b0;
        end else begin
            ball_reset_q <= 1'b0;
            if (frame_tick_i) tick_q <= tick_q + 8'd1;
            case (state_q)
                ST_IDLE: begin
                    if (serve_1 || serve_2) begin
                        serve_side_q <= !serve_1;
                        state_q      <= ST_SERVE;
                        ball_reset_q <= 1'b1;
                        tick_q       <= 8'd0;
                    end
                end
                ST_SERVE: begin
                    if (serve_own || serve_timeout) begin
                        state_q <= ST_PLAY;
                        run_q   <= 1'b1;
                        tick_q  <= 8'd0;
                    end
                end
                ST_PLAY: begin
                    if (miss_1_i) begin
                        score_2_q    <= score_2_d;
                        serve_side_q <= 1'b0;
                        run_q        <= 1'b0;
                        tick_q       <= 8'd0;
                        if (score_2_d == WIN_LIM) begin
                            state_q  <= ST_GAME_OVER;
                            winner_q <= WIN_P2;
                        end else begin
                            state_q  <= ST_POINT;
                        end
                    end else if (miss_2_i) begin
                        score_1_q    <= score_1_d;
                        serve_side_q <= 1'b1;
                        run_q        <= 1'b0;
                        tick_q       <= 8'd0;
                        if (score_1_d == WIN_LIM) begin
                            state_q  <= ST_GAME_OVER;
                            winner_q <= WIN_P1;
                        end else begin
                            state_q  <= ST_POINT;
                        end
                    end else if (pause_1 || pause_2) begin
                        state_q <= ST_PAUSE;
                        run_q   <= 1'b0;
                        tick_q  <= 8'd0;
                    end
                end
                ST_PAUSE: begin
                    if (pause_1 || pause_2) begin
                        state_q <= ST_PLAY;
                        run_q   <= 1'b1;
                        tick_q  <= 8'd0;
                    end
                end
                ST_POINT: begin
                    if (point_done) begin
                        state_q      <= ST_SERVE;
                        ball_reset_q <= 1'b1;
                        tick_q       <= 8'd0;
                    end
                end
                ST_GAME_OVER: begin
                    // Loser keeps the serve for the rematch.
                    if (serve_1 || serve_2) begin
                        score_1_q    <= '0;
                        score_2_q    <= '0;
                        winner_q     <= WIN_NONE;
                        state_q      <= ST_SERVE;
                        ball_reset_q <= 1'b1;
                        tick_q       <= 8'd0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    run_q   <= 1'b0;
                    tick_q  <= 8'd0;
                end
            endcase
        end
    end

    assign run_o        = run_q;
    assign ball_reset_o = ball_reset_q;
    assign serve_side_o = serve_side_q;
    assign score_1_o    = score_1_q;
    assign score_2_o    = score_2_q;
    assign winner_o     = winner_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: directed scenarios plus a randomized event run
// checked against an event-level match model.
module tb_game_controller;

    localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_PAUSE = 3, S_POINT = 4, S_GO = 5;
    localparam int WIN = 7, HOLD = 60, TMO = 180;
`ifdef GAME_CONTROLLER_AUTO_SERVE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    localparam logic [3:0] K_SERVE = 4'd1;
    localparam logic [3:0] K_PAUSE = 4'd4;

    logic       CLOCK_25 = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick_i = 1'b0;
    logic [3:0] keys_1_i = 4'd0, keys_2_i = 4'd0;
    logic       miss_1_i = 1'b0, miss_2_i = 1'b0;
    logic       run_o, ball_reset_o, serve_side_o;
    logic [2:0] score_1_o, score_2_o, state_o;
    logic [1:0] winner_o;

    game_controller #(.WIN_SCORE(WIN), .POINT_HOLD(HOLD), .SERVE_TIMEOUT(TMO)) dut (
        .CLOCK_25     (CLOCK_25),
        .reset        (reset),
        .frame_tick_i (frame_tick_i),
        .keys_1_i     (keys_1_i),
        .keys_2_i     (keys_2_i),
        .miss_1_i     (miss_1_i),
        .miss_2_i     (miss_2_i),
        .run_o        (run_o),
        .ball_reset_o (ball_reset_o),
        .serve_side_o (serve_side_o),
        .score_1_o    (score_1_o),
        .score_2_o    (score_2_o),
        .winner_o     (winner_o),
        .state_o      (state_o)
    );

    always #20 CLOCK_25 = ~CLOCK_25;

    int cmps = 0;
    int errs = 0;
    int br_count = 0;

    always @(negedge CLOCK_25) if (ball_reset_o === 1'b1) br_count++;

    // Event-level model of the match.
    int m_ph, m_s1, m_s2, m_win, m_side, m_cnt, m_br;

    function automatic void m_init();
        m_ph = S_IDLE; m_s1 = 0; m_s2 = 0; m_win = 0; m_side = 0; m_cnt = 0; m_br = 0;
    endfunction

    function automatic void m_set(int ph);
        if (ph == S_SERVE) m_br++;
        m_ph = ph;
        m_cnt = 0;
    endfunction

    function automatic void m_serve(bit p1, bit p2);
        if (!(p1 || p2)) return;
        if (m_ph == S_IDLE) begin
            m_side = p1 ? 0 : 1;
            m_set(S_SERVE);
        end else if (m_ph == S_SERVE) begin
            if ((m_side == 0 && p1) || (m_side == 1 && p2)) m_set(S_PLAY);
        end else if (m_ph == S_GO) begin
            m_s1 = 0; m_s2 = 0; m_win = 0;
            m_set(S_SERVE);
        end
    endfunction

    function automatic void m_pause(bit p1, bit p2);
        if (!(p1 || p2)) return;
        if (m_ph == S_PLAY) m_set(S_PAUSE);
        else if (m_ph == S_PAUSE) m_set(S_PLAY);
    endfunction

    function automatic void m_miss(bit a, bit b);
        if (m_ph != S_PLAY || !(a || b)) return;
        if (a) begin
            m_s2 = (m_s2 + 1 > WIN) ? WIN : m_s2 + 1;
            m_side = 0;
            if (m_s2 == WIN) begin m_win = 2; m_set(S_GO); end else m_set(S_POINT);
        end else begin
            m_s1 = (m_s1 + 1 > WIN) ? WIN : m_s1 + 1;
            m_side = 1;
            if (m_s1 == WIN) begin m_win = 1; m_set(S_GO); end else m_set(S_POINT);
        end
    endfunction

    function automatic void m_tick();
        if (m_ph == S_POINT) begin
            m_cnt++;
            if (m_cnt >= HOLD) m_set(S_SERVE);
        end else if (m_ph == S_SERVE && AUTO) begin
            m_cnt++;
            if (m_cnt >= TMO) m_set(S_PLAY);
        end
    endfunction

    task automatic cyc(int n);
        repeat (n) @(posedge CLOCK_25);
        #1;
    endtask

    task automatic press(bit p1, bit p2, logic [3:0] code);
        if (p1) keys_1_i = code;
        if (p2) keys_2_i = code;
        cyc(5);
        keys_1_i = 4'd0;
        keys_2_i = 4'd0;
        cyc(4);
    endtask

    task automatic miss(bit a, bit b);
        miss_1_i = a; miss_2_i = b;
        cyc(1);
        miss_1_i = 1'b0; miss_2_i = 1'b0;
        cyc(1);
    endtask

    task automatic ticks(int n);
        repeat (n) begin
            frame_tick_i = 1'b1;
            cyc(1);
            frame_tick_i = 1'b0;
            cyc(1);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(3);
        cmps++; if ({state_o, run_o, ball_reset_o, serve_side_o, score_1_o, score_2_o, winner_o} !== 14'd0) begin
            errs++; $display("FAIL reset_values got=%b exp=0", {state_o, run_o, ball_reset_o, serve_side_o, score_1_o, score_2_o, winner_o}); end
        reset = 1'b0;
        cyc(1);
        cmps++; if (state_o !== 3'd0) begin errs++; $display("FAIL reset_release state=%0d exp=0", state_o); end
    endtask

    task automatic test_serve();
        int b0 = br_count;
        keys_1_i = K_SERVE;
        cyc(2);
        cmps++; if (state_o !== 3'd0) begin errs++; $display("FAIL key_latency_early state=%0d exp=0", state_o); end
        cyc(1);
        cmps++; if (state_o !== 3'd1) begin errs++; $display("FAIL key_latency state=%0d exp=1", state_o); end
        cmps++; if (ball_reset_o !== 1'b1) begin errs++; $display("FAIL serve_entry_pulse got=%b exp=1", ball_reset_o); end
        cyc(2);
        keys_1_i = 4'd0;
        cyc(4);
        cmps++; if (br_count - b0 !== 1) begin errs++; $display("FAIL ball_reset_count got=%0d exp=1", br_count - b0); end
        cmps++; if (serve_side_o !== 1'b0) begin errs++; $display("FAIL idle_side got=%b exp=0", serve_side_o); end
        press(1, 0, K_SERVE);
        cmps++; if ({state_o, run_o} !== {3'd2, 1'b1}) begin errs++; $display("FAIL serve_to_play state=%0d run=%b exp=2/1", state_o, run_o); end
    endtask

    task automatic test_point();
        int b0;
        miss_2_i = 1'b1;
        cyc(1);
        miss_2_i = 1'b0;
        cmps++; if ({score_1_o, state_o, run_o, serve_side_o} !== {3'd1, 3'd4, 1'b0, 1'b1}) begin
            errs++; $display("FAIL miss2_update s1=%0d st=%0d run=%b side=%b exp=1/4/0/1", score_1_o, state_o, run_o, serve_side_o); end
        cyc(1);
        b0 = br_count;
        ticks(HOLD - 1);
        cmps++; if (state_o !== 3'd4) begin errs++; $display("FAIL point_hold_early state=%0d exp=4", state_o); end
        ticks(1);
        cmps++; if (state_o !== 3'd1) begin errs++; $display("FAIL point_exit state=%0d exp=1", state_o); end
        cyc(2);
        cmps++; if (br_count - b0 !== 1) begin errs++; $display("FAIL point_ball_reset got=%0d exp=1", br_count - b0); end
        press(1, 0, K_SERVE);
        cmps++; if (state_o !== 3'd1) begin errs++; $display("FAIL wrong_server state=%0d exp=1", state_o); end
        press(0, 1, K_SERVE);
        cmps++; if (state_o !== 3'd2) begin errs++; $display("FAIL right_server state=%0d exp=2", state_o); end
    endtask

    task automatic test_double_miss();
        miss(1, 1);
        cmps++; if ({score_1_o, score_2_o, state_o, serve_side_o} !== {3'd1, 3'd1, 3'd4, 1'b0}) begin
            errs++; $display("FAIL double_miss s1=%0d s2=%0d st=%0d side=%b exp=1/1/4/0", score_1_o, score_2_o, state_o, serve_side_o); end
        ticks(HOLD);
        press(1, 0, K_SERVE);
    endtask

    task automatic test_game_over();
        repeat (5) begin
            miss(1, 0);
            ticks(HOLD);
            press(1, 0, K_SERVE);
        end
        cmps++; if ({score_2_o, state_o} !== {3'd6, 3'd2}) begin errs++; $display("FAIL pre_win s2=%0d st=%0d exp=6/2", score_2_o, state_o); end
        miss(1, 0);
        cmps++; if ({score_2_o, winner_o, state_o, run_o} !== {3'd7, 2'b10, 3'd5, 1'b0}) begin
            errs++; $display("FAIL win s2=%0d win=%b st=%0d run=%b exp=7/10/5/0", score_2_o, winner_o, state_o, run_o); end
        miss(1, 0);
        miss(0, 1);
        cmps++; if ({score_1_o, score_2_o, state_o} !== {3'd1, 3'd7, 3'd5}) begin
            errs++; $display("FAIL go_hold s1=%0d s2=%0d st=%0d exp=1/7/5", score_1_o, score_2_o, state_o); end
        press(1, 0, K_SERVE);
        cmps++; if ({score_1_o, score_2_o, winner_o, state_o, serve_side_o} !== {3'd0, 3'd0, 2'b00, 3'd1, 1'b0}) begin
            errs++; $display("FAIL rematch s1=%0d s2=%0d win=%b st=%0d side=%b exp=0/0/00/1/0", score_1_o, score_2_o, winner_o, state_o, serve_side_o); end
    endtask

    task automatic test_pause();
        press(1, 0, K_SERVE);
        press(1, 0, K_PAUSE);
        cmps++; if ({state_o, run_o} !== {3'd3, 1'b0}) begin errs++; $display("FAIL pause state=%0d run=%b exp=3/0", state_o, run_o); end
        miss(1, 0);
        cmps++; if ({score_2_o, state_o} !== {3'd0, 3'd3}) begin errs++; $display("FAIL pause_miss s2=%0d st=%0d exp=0/3", score_2_o, state_o); end
        press(0, 1, K_PAUSE);
        cmps++; if ({state_o, run_o} !== {3'd2, 1'b1}) begin errs++; $display("FAIL unpause state=%0d run=%b exp=2/1", state_o, run_o); end
        keys_1_i = K_PAUSE;
        cyc(2);
        miss_2_i = 1'b1;
        cyc(1);
        miss_2_i = 1'b0;
        cmps++; if ({state_o, score_1_o} !== {3'd4, 3'd1}) begin errs++; $display("FAIL miss_over_pause st=%0d s1=%0d exp=4/1", state_o, score_1_o); end
        cyc(3);
        keys_1_i = 4'd0;
        cyc(4);
        ticks(HOLD);
        press(0, 1, K_SERVE);
    endtask

    task automatic test_reset_mid();
        miss(0, 1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cmps++; if ({state_o, run_o, serve_side_o, score_1_o, score_2_o, winner_o} !== 13'd0) begin
            errs++; $display("FAIL reset_mid got=%b exp=0", {state_o, run_o, serve_side_o, score_1_o, score_2_o, winner_o}); end
        cyc(1);
    endtask

    task automatic test_timeout();
        press(0, 1, K_SERVE);
        cmps++; if ({state_o, serve_side_o} !== {3'd1, 1'b1}) begin errs++; $display("FAIL idle_p2 st=%0d side=%b exp=1/1", state_o, serve_side_o); end
        if (AUTO) begin
            ticks(TMO - 1);
            cmps++; if (state_o !== 3'd1) begin errs++; $display("FAIL timeout_early state=%0d exp=1", state_o); end
            ticks(1);
            cmps++; if ({state_o, run_o} !== {3'd2, 1'b1}) begin errs++; $display("FAIL timeout state=%0d run=%b exp=2/1", state_o, run_o); end
        end else begin
            ticks(500);
            cmps++; if (state_o !== 3'd1) begin errs++; $display("FAIL no_timeout state=%0d exp=1", state_o); end
        end
    endtask

    task automatic test_random();
        int b0;
        logic [12:0] got, exp;
        do_reset();
        m_init();
        b0 = br_count;
        for (int i = 0; i < 150; i++) begin
            int r = $urandom_range(0, 9);
            if (r <= 2) begin
                int w = $urandom_range(1, 3);
                press(w[0], w[1], K_SERVE);
                m_serve(w[0], w[1]);
            end else if (r <= 4) begin
                int w = $urandom_range(1, 3);
                press(w[0], w[1], K_PAUSE);
                m_pause(w[0], w[1]);
            end else if (r <= 7) begin
                int w = $urandom_range(1, 3);
                miss(w[0], w[1]);
                m_miss(w[0], w[1]);
            end else begin
                int k = $urandom_range(1, 70);
                ticks(k);
                repeat (k) m_tick();
            end
            cyc(1);
            got = {state_o, run_o, serve_side_o, score_1_o, score_2_o, winner_o};
            exp = {3'(m_ph), (m_ph == S_PLAY), 1'(m_side), 3'(m_s1), 3'(m_s2), 2'(m_win)};
            cmps++; if (got !== exp) begin errs++; $display("FAIL random_%0d outputs got=%b exp=%b", i, got, exp); end
            cmps++; if (br_count - b0 !== m_br) begin errs++; $display("FAIL random_%0d ball_resets got=%0d exp=%0d", i, br_count - b0, m_br); end
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_point();
        test_double_miss();
        test_game_over();
        test_pause();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
